// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage.
//   - INSTR_W / PC_W        : datapath widths
//   - NOP_WORD              : sll $0,$0,0, the word used for bubbles and flushes
//   - IFID_* offsets        : packed IF/ID layout {pc_plus4[63:32], instr[31:0]}
//   - fetch_state_e         : fetch FSM states
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  localparam int IFID_INSTR_LSB = 0;
  localparam int IFID_INSTR_MSB = 31;
  localparam int IFID_PC4_LSB   = 32;
  localparam int IFID_PC4_MSB   = 63;
  localparam int IFID_W         = 64;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch response that arrives while decode
// is stalled.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load, din  : capture din and mark full
//   clear      : empty the buffer (wins over load)
//   full, dout : occupancy flag and held IF/ID word
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [IFID_W-1:0] din,
  output logic              full,
  output logic [IFID_W-1:0] dout
);
  logic              full_q, full_d;
  logic [IFID_W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;
endmodule

// File: rtl/fetch_pipe_unit.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   branch_taken, branch_target   : MEM-stage redirect (target bits [1:0] ignored)
//   stall                         : hazard-unit freeze of PC and IF/ID
//   imem_req, imem_addr           : fetch request and word-aligned address
//   imem_ready, imem_rdata        : response strobe and instruction word
//   if_id_instr/pc_plus4/valid    : IF/ID register towards decode
//   dbg_state                     : current fetch FSM state
//   perf_fetched, perf_bubbles    : only when FETCH_PERF_CNT_EN is defined
//
// Handshake: a transfer completes in any cycle where imem_req=1 and
// imem_ready=1; imem_rdata belongs to that cycle. While imem_req=1 and
// imem_ready=0 the address is held stable. After a redirect the abandoned
// request is kept on the bus (DISCARD) until its response arrives and is
// dropped.
module fetch_pipe_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus4,
  output logic               if_id_valid,
  output fetch_state_e       dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);
  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   disc_addr_q, disc_addr_d;
  logic [IFID_W-1:0] if_id_q, if_id_d;
  logic              if_id_valid_q, if_id_valid_d;

  logic              skid_load, skid_clear, skid_full;
  logic [IFID_W-1:0] skid_dout;
  logic [PC_W-1:0]   pc_plus4;
  logic              fire;

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   ({pc_plus4, imem_rdata}),
    .full  (skid_full),
    .dout  (skid_dout)
  );

  assign pc_plus4 = pc_q + 32'd4;
  // No new request while a stalled response is parked in the skid buffer.
  assign imem_req  = ((state_q == S_REQ) && !skid_full) || (state_q == S_DISCARD);
  assign imem_addr = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
  assign fire      = imem_req && imem_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    disc_addr_d   = disc_addr_q;
    if_id_d       = if_id_q;
    if_id_valid_d = if_id_valid_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;

    case (state_q)
      S_IDLE:    state_d = S_REQ;
      S_REQ:     state_d = S_REQ;
      S_DISCARD: if (imem_ready) state_d = S_REQ;
      default:   state_d = S_IDLE;
    endcase

    if (branch_taken) begin
      // Redirect beats stall and any same-cycle response.
      if_id_d       = {{PC_W{1'b0}}, NOP_INSTR};
      if_id_valid_d = 1'b0;
      skid_clear    = 1'b1;
      pc_d          = branch_target & ~32'h3;
      if (imem_req && !imem_ready) begin
        state_d = S_DISCARD;
        // A redirect while already discarding keeps the original address on the bus.
        if (state_q == S_REQ) disc_addr_d = pc_q;
      end else begin
        state_d = S_REQ;
      end
    end else if (stall) begin
      if ((state_q == S_REQ) && fire) skid_load = 1'b1;
    end else if (skid_full) begin
      // Parked word goes to decode first; PC only advances now.
      if_id_d       = skid_dout;
      if_id_valid_d = 1'b1;
      skid_clear    = 1'b1;
      pc_d          = pc_plus4;
    end else if ((state_q == S_REQ) && fire) begin
      if_id_d       = {pc_plus4, imem_rdata};
      if_id_valid_d = 1'b1;
      pc_d          = pc_plus4;
    end else begin
      if_id_d       = {{PC_W{1'b0}}, NOP_INSTR};
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      disc_addr_q   <= '0;
      if_id_q       <= {{PC_W{1'b0}}, NOP_INSTR};
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      disc_addr_q   <= disc_addr_d;
      if_id_q       <= if_id_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign if_id_instr    = if_id_q[IFID_INSTR_MSB:IFID_INSTR_LSB];
  assign if_id_pc_plus4 = if_id_q[IFID_PC4_MSB:IFID_PC4_LSB];
  assign if_id_valid    = if_id_valid_q;
  assign dbg_state      = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // IF/ID is written every cycle except a plain stall.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (branch_taken || !stall) begin
      if (if_id_valid_d) perf_fetched_d = perf_fetched_q + 32'd1;
      else               perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif
endmodule

// File: tb/tb_fetch_pipe_unit.sv
// Testbench for fetch_pipe_unit: variable-latency memory returning
// address-as-data, IF/ID scoreboard and fetch-address model.
module tb_fetch_pipe_unit;
  import mips_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  fetch_state_e dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  always #5 clk = ~clk;

  fetch_pipe_unit dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .dbg_state      (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];      // {pc_plus4, instr} accepted but not yet in IF/ID
  logic [31:0] m_pc;          // expected fetch address
  logic        m_idle;        // first cycle after reset issues no request
  logic        drop_next;     // a redirected request is still outstanding
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  int          exp_fetched;
  int          exp_bubbles;
  int          mem_lat;
  int          mem_cnt;
  bit          mem_block;

  task automatic model_reset();
    exp_q.delete();
    m_pc        = 32'h0;
    m_idle      = 1'b1;
    drop_next   = 1'b0;
    m_valid     = 1'b0;
    m_instr     = NOP;
    m_pc4       = 32'h0;
    exp_fetched = 0;
    exp_bubbles = 0;
    mem_cnt     = 0;
    imem_ready  = 1'b0;
  endtask

  // One clock cycle. Entered and left at the falling edge; the caller has
  // already set stall / branch_taken / branch_target for this cycle.
  task automatic tick();
    logic [63:0] e;
    logic        exp_req;
    logic        load;
    exp_req = !m_idle && (drop_next || exp_q.size() == 0);
    checks++;
    if (imem_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req: got %b expected %b at %0t", imem_req, exp_req, $time);
    end
    if (exp_req && !drop_next) begin
      checks++;
      if (imem_addr !== m_pc) begin
        errors++;
        $display("FAIL imem_addr: got %h expected %h at %0t", imem_addr, m_pc, $time);
      end
    end
    // memory: respond mem_lat cycles into a held request
    if (imem_req && !mem_block) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        imem_ready = 1'b1;
        imem_rdata = imem_addr;
        mem_cnt    = 0;
      end else begin
        imem_ready = 1'b0;
      end
    end else begin
      imem_ready = 1'b0;
      mem_cnt    = 0;
    end
    // expected-queue push on an accepted response
    if (imem_req && imem_ready) begin
      if (drop_next || branch_taken) drop_next = 1'b0;
      else exp_q.push_back({m_pc + 32'd4, m_pc});
    end
    if (branch_taken) begin
      exp_q.delete();
      if (imem_req && !imem_ready) drop_next = 1'b1;
    end
    m_idle = 1'b0;
    load = branch_taken || !stall;
    if (!branch_taken && !stall && exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      m_valid = 1'b1;
      m_instr = e[31:0];
      m_pc4   = e[63:32];
      m_pc    = m_pc + 32'd4;
      exp_fetched++;
    end else if (load) begin
      m_valid = 1'b0;
      m_instr = NOP;
      m_pc4   = 32'h0;
      exp_bubbles++;
    end
    if (branch_taken) m_pc = branch_target & ~32'h3;
    @(posedge clk);
    #1;
    checks++;
    if (if_id_valid !== m_valid || if_id_instr !== m_instr || if_id_pc_plus4 !== m_pc4) begin
      errors++;
      $display("FAIL if_id: got v=%b i=%h p=%h expected v=%b i=%h p=%h at %0t",
               if_id_valid, if_id_instr, if_id_pc_plus4, m_valid, m_instr, m_pc4, $time);
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0; mem_block = 1'b0; mem_lat = 1;
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== NOP ||
        if_id_pc_plus4 !== 32'h0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got req=%b v=%b i=%h p=%h st=%0d expected 0 0 %h 0 %0d",
               imem_req, if_id_valid, if_id_instr, if_id_pc_plus4, dbg_state, NOP, S_IDLE);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'h0 || perf_bubbles !== 32'h0) begin
      errors++;
      $display("FAIL reset_perf: got %0d %0d expected 0 0", perf_fetched, perf_bubbles);
    end
`endif
    rst = 1'b0;
    model_reset();
    repeat (4) tick();
    // asynchronous reset in the middle of streaming
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL async_reset: got req=%b v=%b p=%h st=%0d expected 0 0 0 %0d",
               imem_req, if_id_valid, if_id_pc_plus4, dbg_state, S_IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    mem_lat = 1; mem_cnt = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_addr !== 32'(i * 4)) begin
        errors++;
        $display("FAIL stream_addr: got %h expected %h", imem_addr, 32'(i * 4));
      end
      tick();
    end
    checks++;
    if (if_id_pc_plus4 !== 32'h10 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL stream_pc4: got %h v=%b expected 00000010 v=1", if_id_pc_plus4, if_id_valid);
    end
  endtask

  task automatic test_latency();
    int n;
    n = 0;
    mem_lat = 3; mem_cnt = 0;
    repeat (9) begin
      tick();
      if (if_id_valid === 1'b1) n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL latency_pulses: got %0d expected 3", n);
    end
  endtask

  task automatic test_stall();
    logic [31:0] cap;
    mem_lat = 1; mem_cnt = 0;
    repeat (2) tick();
    cap   = m_pc;
    stall = 1'b1;
    repeat (4) tick();
    stall = 1'b0;
    tick();
    checks++;
    if (if_id_instr !== cap || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got i=%h v=%b expected i=%h v=1", if_id_instr, if_id_valid, cap);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== cap + 32'd4) begin
      errors++;
      $display("FAIL stall_next_addr: got req=%b a=%h expected 1 %h", imem_req, imem_addr, cap + 32'd4);
    end
    repeat (3) tick();
  endtask

  task automatic discard_wait(input logic [31:0] want);
    for (int k = 0; k < 10 && drop_next; k++) tick();
    checks++;
    if (drop_next) begin
      errors++;
      $display("FAIL discard_timeout: got pending=1 expected 0");
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== want) begin
      errors++;
      $display("FAIL redirect_addr: got req=%b a=%h expected 1 %h", imem_req, imem_addr, want);
    end
  endtask

  task automatic test_branch_outstanding();
    mem_lat = 2; mem_cnt = 0;
    mem_block = 1'b1;
    tick();
    branch_taken = 1'b1; branch_target = 32'h0000_0043;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (dbg_state !== S_DISCARD || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL discard_enter: got st=%0d req=%b v=%b expected %0d 1 0",
               dbg_state, imem_req, if_id_valid, S_DISCARD);
    end
    tick();
    mem_block = 1'b0;
    discard_wait(32'h0000_0040);
    repeat (3) tick();
    // second redirect while still discarding
    mem_block = 1'b1;
    tick();
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    branch_target = 32'h0000_0307;
    tick();
    branch_taken = 1'b0;
    mem_block = 1'b0;
    discard_wait(32'h0000_0304);
    repeat (3) tick();
  endtask

  task automatic test_branch_stall();
    mem_lat = 1; mem_cnt = 0;
    repeat (2) tick();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_1000;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    checks++;
    if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL branch_stall: got v=%b req=%b a=%h expected 0 1 00001000",
               if_id_valid, imem_req, imem_addr);
    end
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    mem_lat = 1; mem_cnt = 0;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    checks++;
    if (if_id_pc_plus4 !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_pc4: got p=%h v=%b i=%h expected 00000000 1 fffffffc",
               if_id_pc_plus4, if_id_valid, if_id_instr);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %h expected 00000000", imem_addr);
    end
    repeat (2) tick();
  endtask

  task automatic test_perf();
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'(exp_fetched) || perf_bubbles !== 32'(exp_bubbles)) begin
      errors++;
      $display("FAIL perf: got %0d/%0d expected %0d/%0d", perf_fetched, perf_bubbles,
               exp_fetched, exp_bubbles);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_branch_outstanding();
    test_branch_stall();
    test_perf();
    test_wrap();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
